// File: rtl/adder12_pkg.sv
// Shared types and constants for the adder12 frame controller.
// Holds the sample/sum widths, lane count and FSM state encoding.
package adder12_pkg;

    localparam int SAMPLE_W = 12;
    localparam int SUM_W    = 15;
    localparam int NLANE    = 8;
    localparam int IDX_W    = $clog2(NLANE);

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SUM_W-1:0]    sum_t;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD = ST_LOAD,
        S_WAIT = ST_WAIT,
        S_OUT  = ST_OUT
    } state_t;

endpackage

// File: rtl/adder12_frame_ctrl_lane_loader.sv
// lane_loader: write index counter plus the 8 x 12-bit lane register file.
// Ports: clk, rst (sync, high), i_clr (index clear, lanes kept),
//        i_we/i_data (write sample into lane idx), o_last (idx==7), o_lanes.
module lane_loader
    import adder12_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  sample_t               i_data,
    output logic                  o_last,
    output sample_t [NLANE-1:0]   o_lanes
);

    logic [IDX_W-1:0]    r_idx;
    sample_t [NLANE-1:0] r_lanes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_lanes <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_we) begin
            r_lanes[r_idx] <= i_data;
            // Natural 3-bit wrap: 7->0 only happens on the 8th write
            r_idx          <= r_idx + 1'b1;
        end
    end

    assign o_last  = (r_idx == IDX_W'(NLANE - 1));
    assign o_lanes = r_lanes;

endmodule

// File: rtl/adder12_frame_ctrl.sv
// adder12_frame_ctrl: collects 8 samples into lanes, waits for the external
// adder latency, captures the sum and offers it on a valid/ready output.
// Ports: clk, rst (sync, high), clr (frame abort), s_valid/s_ready/s_data,
//        n0..n7 (lanes to adder), add_sum, res_valid/res_ready/res_sum, busy.
// Option: define MEAN_OUT_EN to add res_mean = res_sum >>> 3.
module adder12_frame_ctrl
    import adder12_pkg::*;
#(
    parameter int ADD_LAT = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    s_valid,
    output logic    s_ready,
    input  sample_t s_data,
    output sample_t n0,
    output sample_t n1,
    output sample_t n2,
    output sample_t n3,
    output sample_t n4,
    output sample_t n5,
    output sample_t n6,
    output sample_t n7,
    input  sum_t    add_sum,
    output logic    res_valid,
    input  logic    res_ready,
    output sum_t    res_sum,
`ifdef MEAN_OUT_EN
    output sample_t res_mean,
`endif
    output logic    busy
);

    if (ADD_LAT < 1 || ADD_LAT > 15) begin : g_bad_lat
        $error("ADD_LAT out of range 1..15");
    end
    if (NLANE != 8) begin : g_bad_nlane
        $error("NLANE must be 8");
    end

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_lat_cnt;
    logic                r_res_valid;
    sum_t                r_res_sum;
    logic                w_we;
    logic                w_last;
    logic                w_lat_done;
    sample_t [NLANE-1:0] w_lanes;

    lane_loader u_lanes (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr),
        .i_we    (w_we),
        .i_data  (s_data),
        .o_last  (w_last),
        .o_lanes (w_lanes)
    );

    // Lanes changed on the WAIT entry edge; the adder output is valid
    // ADD_LAT clocks later, so capture on the following edge.
    assign w_lat_done = (r_lat_cnt == 4'(ADD_LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                w_we = s_valid && !clr;
                if (s_valid && w_last) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_lat_done) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    w_next = S_LOAD;
                end
            end
            default: w_next = S_LOAD;
        endcase
        if (clr) begin
            w_next = S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr || r_state != S_WAIT) begin
            r_lat_cnt <= '0;
        end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
        end
    end

`ifdef MEAN_OUT_EN
    sample_t r_res_mean;
    sum_t    w_mean_full;

    assign w_mean_full = sum_t'($signed(add_sum) >>> 3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_mean <= '0;
        end else if (!clr && r_state == S_WAIT && w_lat_done) begin
            r_res_mean <= w_mean_full[SAMPLE_W-1:0];
        end
    end

    assign res_mean = r_res_mean;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
        end else if (clr) begin
            r_res_valid <= 1'b0;
        end else if (r_state == S_WAIT && w_lat_done) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= add_sum;
        end else if (r_state == S_OUT && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign s_ready   = (r_state == S_LOAD);
    assign busy      = (r_state != S_LOAD);
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;

    assign n0 = w_lanes[0];
    assign n1 = w_lanes[1];
    assign n2 = w_lanes[2];
    assign n3 = w_lanes[3];
    assign n4 = w_lanes[4];
    assign n5 = w_lanes[5];
    assign n6 = w_lanes[6];
    assign n7 = w_lanes[7];

endmodule

// File: tb/tb_adder12_frame_ctrl.sv
// Directed bench for adder12_frame_ctrl with a registered 8-lane adder model.
// Covers reset, sums, latency, backpressure, clr abort and rst in WAIT.
module tb_adder12_frame_ctrl;
    import adder12_pkg::*;

    localparam int ADD_LAT = 2;

    logic    clk = 1'b0;
    logic    rst, clr, s_valid, s_ready, res_valid, res_ready, busy;
    sample_t s_data;
    sample_t n0, n1, n2, n3, n4, n5, n6, n7;
    sum_t    add_sum, res_sum;
`ifdef MEAN_OUT_EN
    sample_t res_mean;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #10 clk = ~clk;

    adder12_frame_ctrl #(.ADD_LAT(ADD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .n0        (n0),
        .n1        (n1),
        .n2        (n2),
        .n3        (n3),
        .n4        (n4),
        .n5        (n5),
        .n6        (n6),
        .n7        (n7),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
`ifdef MEAN_OUT_EN
        .res_mean  (res_mean),
`endif
        .busy      (busy)
    );

    // Adder model: ADD_LAT register stages over the sign-extended lanes
    sum_t pipe [ADD_LAT];
    sum_t w_sum;
    assign w_sum = 15'($signed(n0)) + 15'($signed(n1)) + 15'($signed(n2))
                 + 15'($signed(n3)) + 15'($signed(n4)) + 15'($signed(n5))
                 + 15'($signed(n6)) + 15'($signed(n7));
    always @(posedge clk) begin
        pipe[0] <= w_sum;
        for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign add_sum = pipe[ADD_LAT-1];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input sample_t a, input sample_t b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = (i % 2 == 1) ? b : a;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Called at the negedge after the 8th accept edge
    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic frame(input string tag, input sample_t a, input sample_t b,
                         input sum_t exp_sum, input sample_t exp_mean);
        int cyc;
        send(a, b, 8);
        wait_res(cyc);
        check({tag, "_lat"}, cyc, ADD_LAT + 1);
        check({tag, "_sum"}, res_sum, exp_sum);
`ifdef MEAN_OUT_EN
        check({tag, "_mean"}, res_mean, exp_mean);
`else
        if (exp_mean === 'x) $display("unused");
`endif
        handshake();
        check({tag, "_rdy"}, {res_valid, s_ready, busy}, 3'b010);
    endtask

    initial begin
        int cyc;
        int bad;
        rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", {res_valid, s_ready, busy}, 3'b010);
        check("rst_sum", res_sum, 0);
        check("rst_lanes", {n0, n7}, 0);
        rst = 1'b0;

        // T1/T2/T3
        frame("t1", 12'hfff, 12'hfff, 15'h7ff8, 12'hfff);
        frame("t2p", 12'h7ff, 12'h7ff, 15'h3ff8, 12'h7ff);
        frame("t2n", 12'h800, 12'h800, 15'h4000, 12'h800);
        frame("t3a", 12'haaa, 12'h555, 15'h7ffc, 12'hfff);
        frame("t3b", 12'h001, 12'hfff, 15'h0000, 12'h000);

        // T4: backpressure with a sample offered the whole time
        send(12'h010, 12'h010, 8);
        wait_res(cyc);
        check("t4_lat", cyc, ADD_LAT + 1);
        s_valid = 1'b1; s_data = 12'h123;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!res_valid || res_sum !== 15'h0080 || s_ready || !busy) bad++;
        end
        check("t4_hold", bad, 0);
        check("t4_nolane", n0, 12'h010);
        s_valid = 1'b0;
        handshake();
        check("t4_rel", {res_valid, s_ready}, 2'b01);

        // T5: abort after 5 samples, then a clean frame
        send(12'h100, 12'h100, 5);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_clr", {res_valid, busy, s_ready}, 3'b001);
        frame("t5", 12'h001, 12'h001, 15'h0008, 12'h001);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        check("t5_onepulse", bad, 0);

        // T6: rst while in WAIT
        send(12'h7ff, 12'h7ff, 8);
        check("t6_wait", {busy, s_ready}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_out", {res_valid, s_ready, busy}, 3'b010);
        check("t6_sum", res_sum, 0);
        check("t6_lanes", {n0, n3, n7}, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || res_sum !== 15'h0) bad++;
        end
        check("t6_nores", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
